// File: rtl/ele_pkg.sv
// Shared definitions for the elevator buzzer: chime FSM encoding, default
// audio timing constants and helpers for half-period and counter-width math.
package ele_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TONE1 = 3'd1,
    ST_GAP   = 3'd2,
    ST_TONE2 = 3'd3,
    ST_HOLD  = 3'd4
  } buzz_state_t;

  localparam int DEF_CLK_HZ     = 50_000_000;
  localparam int DEF_TONE_HI_HZ = 2000;
  localparam int DEF_TONE_LO_HZ = 1000;
  localparam int DEF_BEEP_MS    = 100;
  localparam int DEF_GAP_MS     = 50;

  // Clock cycles spent in each half of a square wave at tone_hz.
  function automatic int half_period(input int clk_hz, input int tone_hz);
    return clk_hz / (2 * tone_hz);
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/buzzer_ctrl_tone_div.sv
// Square-wave divider: toggles phase every half_cnt enabled cycles.
// clr restarts the wave in its low half so every tone starts identically.
module tone_div #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         sysclr,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] half_cnt,
  output logic         phase
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge sysclr) begin
    if (sysclr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (en) begin
      if (cnt == half_cnt - W'(1)) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/buzzer_ctrl.sv
// Arrival chime generator: a rising beep_en plays high tone, gap, low tone on
// the BUZZER pin; a level held past the chime parks in HOLD instead of repeating.
module buzzer_ctrl
  import ele_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int TONE_HI_HZ = DEF_TONE_HI_HZ,
  parameter int TONE_LO_HZ = DEF_TONE_LO_HZ,
  parameter int BEEP_MS    = DEF_BEEP_MS,
  parameter int GAP_MS     = DEF_GAP_MS
) (
  input  logic clk,
  input  logic sysclr,
  input  logic beep_en,
  input  logic mute,
  output logic buzzer,
  output logic busy
);

  localparam int MS_DIV   = CLK_HZ / 1000;
  localparam int HALF_HI  = half_period(CLK_HZ, TONE_HI_HZ);
  localparam int HALF_LO  = half_period(CLK_HZ, TONE_LO_HZ);
  localparam int HALF_MAX = (HALF_HI > HALF_LO) ? HALF_HI : HALF_LO;
  localparam int MS_MAX   = (BEEP_MS > GAP_MS) ? BEEP_MS : GAP_MS;

  localparam int PRESC_W = cnt_width(MS_DIV);
  localparam int MS_W    = cnt_width(MS_MAX);
  localparam int TONE_W  = cnt_width(HALF_MAX + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(MS_DIV - 1);
  localparam logic [MS_W-1:0]    BEEP_LAST  = MS_W'(BEEP_MS - 1);
  localparam logic [MS_W-1:0]    GAP_LAST   = MS_W'(GAP_MS - 1);
  localparam logic [TONE_W-1:0]  HALF_HI_C  = TONE_W'(HALF_HI);
  localparam logic [TONE_W-1:0]  HALF_LO_C  = TONE_W'(HALF_LO);

  buzz_state_t        state;
  buzz_state_t        state_next;
  logic               beep_en_d;
  logic               rise;
  logic [PRESC_W-1:0] presc;
  logic [MS_W-1:0]    ms_cnt;
  logic               tick;
  logic               state_chg;
  logic               tone_on;
  logic               phase;
  logic [TONE_W-1:0]  half_cnt;

  assign rise      = beep_en & ~beep_en_d;
  assign tick      = (presc == PRESC_LAST);
  assign state_chg = (state_next != state);
  assign half_cnt  = (state == ST_TONE1) ? HALF_HI_C : HALF_LO_C;

  always_ff @(posedge clk or posedge sysclr) begin
    if (sysclr) begin
      beep_en_d <= 1'b0;
    end else begin
      beep_en_d <= beep_en;
    end
  end

  always_ff @(posedge clk or posedge sysclr) begin
    if (sysclr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (rise) state_next = ST_TONE1;
      end
      ST_TONE1: begin
        if (tick && ms_cnt == BEEP_LAST) state_next = ST_GAP;
      end
      ST_GAP: begin
        if (tick && ms_cnt == GAP_LAST) state_next = ST_TONE2;
      end
      ST_TONE2: begin
        if (tick && ms_cnt == BEEP_LAST) state_next = beep_en ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (!beep_en) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    tone_on = 1'b0;
    case (state)
      ST_TONE1, ST_TONE2: begin
        busy    = 1'b1;
        tone_on = 1'b1;
      end
      ST_GAP:  busy = 1'b1;
      default: ;
    endcase
  end

  // Timebase restarts on every state change so each timed state is an exact
  // multiple of MS_DIV cycles.
  always_ff @(posedge clk or posedge sysclr) begin
    if (sysclr) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if (state_chg || !busy) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if (tick) begin
      presc  <= '0;
      ms_cnt <= ms_cnt + MS_W'(1);
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  tone_div #(
    .W(TONE_W)
  ) u_tone_div (
    .clk      (clk),
    .sysclr   (sysclr),
    .clr      (state_chg),
    .en       (tone_on),
    .half_cnt (half_cnt),
    .phase    (phase)
  );

  always_ff @(posedge clk or posedge sysclr) begin
    if (sysclr) begin
      buzzer <= 1'b0;
    end else begin
      buzzer <= phase & tone_on & ~mute;
    end
  end

endmodule

// File: tb/tb_buzzer_ctrl.sv
// Bench for buzzer_ctrl: stimulus queues the expected output changes of each
// chime; a monitor compares every observed change of {busy, buzzer} in order.
module tb_buzzer_ctrl;

  logic clk = 1'b0;
  logic sysclr;
  logic beep_en;
  logic mute;
  logic buzzer;
  logic busy;

  int   cyc = 0;
  int   pass = 0;
  int   total = 0;
  logic clr_probe;
  logic done;
  logic mon_en;
  logic [1:0] prev = 2'b00;

  typedef struct {
    int   cyc;
    logic busy;
    logic bz;
  } ev_t;

  ev_t exp_q[$];

  buzzer_ctrl #(
    .CLK_HZ     (10000),
    .TONE_HI_HZ (1000),
    .TONE_LO_HZ (500),
    .BEEP_MS    (4),
    .GAP_MS     (2)
  ) dut (
    .clk     (clk),
    .sysclr  (sysclr),
    .beep_en (beep_en),
    .mute    (mute),
    .buzzer  (buzzer),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int c, input logic b, input logic z);
    ev_t e;
    e.cyc  = c;
    e.busy = b;
    e.bz   = z;
    exp_q.push_back(e);
  endtask

  // Chime started by a rise in cycle n: TONE1 n+1..n+40, GAP n+41..n+60,
  // TONE2 n+61..n+100; buzzer trails the tone phase by one cycle.
  task automatic push_chime(input int n, input int cnt);
    int ofs[14];
    int bs[14];
    int bz[14];
    ofs = '{1, 7, 12, 17, 22, 27, 32, 37, 42, 72, 82, 92, 101, 102};
    bs  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    bz  = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 0};
    for (int k = 0; k < cnt; k++) push_ev(n + ofs[k], bs[k][0], bz[k][0]);
  endtask

  task automatic start_chime(output int n);
    step();
    n = cyc;
  endtask

  // Drives beep_en high from the current cycle; event offsets are relative to it.
  task automatic run_seq(input int hi_len, input int retrig, input int mute_on,
                         input int mute_off, input int clr_on, input int clr_off,
                         input int len);
    beep_en = 1'b1;
    for (int i = 1; i <= len; i++) begin
      step();
      if (i == hi_len) beep_en = 1'b0;
      if (i == retrig) beep_en = 1'b1;
      if (i == retrig + 1) beep_en = 1'b0;
      if (i == mute_on) mute = 1'b1;
      if (i == mute_off) mute = 1'b0;
      if (i == clr_off) sysclr = 1'b0;
      if (i == clr_on) begin
        #2;
        sysclr    = 1'b1;
        clr_probe = 1'b1;
        #1;
        clr_probe = 1'b0;
      end
    end
  endtask

  initial begin
    int n;
    sysclr    = 1'b0;
    beep_en   = 1'b0;
    mute      = 1'b0;
    clr_probe = 1'b0;
    done      = 1'b0;
    mon_en    = 1'b0;

    #2;
    sysclr    = 1'b1;
    clr_probe = 1'b1;
    #1;
    clr_probe = 1'b0;
    repeat (3) step();
    sysclr = 1'b0;
    mon_en = 1'b1;
    repeat (500) step();

    start_chime(n);
    push_chime(n, 14);
    run_seq(3, -1, -1, -1, -1, -1, 120);

    start_chime(n);
    push_chime(n, 14);
    run_seq(300, -1, -1, -1, -1, -1, 310);
    start_chime(n);
    push_chime(n, 14);
    run_seq(3, -1, -1, -1, -1, -1, 120);

    start_chime(n);
    push_chime(n, 14);
    run_seq(3, 50, -1, -1, -1, -1, 120);

    start_chime(n);
    push_ev(n + 1,   1'b1, 1'b0);
    push_ev(n + 7,   1'b1, 1'b1);
    push_ev(n + 10,  1'b1, 1'b0);
    push_ev(n + 76,  1'b1, 1'b1);
    push_ev(n + 82,  1'b1, 1'b0);
    push_ev(n + 92,  1'b1, 1'b1);
    push_ev(n + 101, 1'b0, 1'b1);
    push_ev(n + 102, 1'b0, 1'b0);
    run_seq(3, -1, 9, 75, -1, -1, 120);

    start_chime(n);
    push_chime(n, 10);
    push_ev(n + 75, 1'b0, 1'b0);
    push_chime(n + 77, 14);
    run_seq(400, -1, -1, -1, 75, 77, 420);

    repeat (20) step();
    done = 1'b1;
  end

  initial begin
    ev_t e;
    logic [1:0] cur;
    forever begin
      @(negedge clk or posedge clr_probe);
      if (clr_probe) begin
        #1;
        total++;
        if (busy === 1'b0 && buzzer === 1'b0) pass++;
        else $display("FAIL async_clear @cyc %0d: busy=%b buzzer=%b, expected busy=0 buzzer=0",
                      cyc, busy, buzzer);
      end else if (done) begin
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          total++;
          $display("FAIL missing_event: nothing observed, expected cyc=%0d busy=%0b buzzer=%0b",
                   e.cyc, e.busy, e.bz);
        end
        $display("%0d/%0d checks passed", pass, total);
        $finish;
      end else if (mon_en) begin
        cur = {busy, buzzer};
        if (cur !== prev) begin
          total++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: cyc=%0d busy=%b buzzer=%b, expected no change",
                     cyc, busy, buzzer);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc == cyc && e.busy === busy && e.bz === buzzer) pass++;
            else $display("FAIL output_event: got cyc=%0d busy=%b buzzer=%b, expected cyc=%0d busy=%0b buzzer=%0b",
                          cyc, busy, buzzer, e.cyc, e.busy, e.bz);
          end
          prev = cur;
        end
      end
    end
  end

endmodule
